rgb2gray_stage: RTL



---
 rtl/gray_pkg.sv | 25 ++
 rtl/gray_mac.sv | 47 ++++
 rtl/rgb2gray_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_pkg
// Description : Shared types and constants for the RGB-to-grayscale stage.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

  localparam int RGB_W      = 24;
  localparam int GRAY_W     = 8;

  localparam int COEF_R     = 77;
  localparam int COEF_G     = 150;
  localparam int COEF_B     = 29;
  localparam int GRAY_SHIFT = 8;

  // Field order matches the FIFO word {R[23:16],G[15:8],B[7:0]}
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pix_t;

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_mac.sv
`default_nettype none
// ============================================================================
// Module      : gray_mac
// Description : Registered 77/150/29 multiply-add; optional round-to-nearest
//               when GRAY_ROUND_EN is defined, truncation otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_mac
  import gray_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  rgb_pix_t          i_pix,
  output logic [GRAY_W-1:0] o_gray
);

  logic [15:0] w_sum;
  logic [16:0] w_acc;
  logic [15:0] r_sum;
  logic        w_unused_bits;

  always_comb begin
    w_sum = 16'(COEF_R) * {8'd0, i_pix.r}
          + 16'(COEF_G) * {8'd0, i_pix.g}
          + 16'(COEF_B) * {8'd0, i_pix.b};
`ifdef GRAY_ROUND_EN
    // Max 65280 + 128 still fits 16 bits, so bit 16 is always zero
    w_acc = {1'b0, w_sum} + 17'(1 << (GRAY_SHIFT - 1));
`else
    w_acc = {1'b0, w_sum};
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= w_acc[15:0];
    end
  end

  assign o_gray        = r_sum[GRAY_SHIFT +: GRAY_W];
  assign w_unused_bits = ^{w_acc[16], r_sum[GRAY_SHIFT-1:0]};

endmodule : gray_mac
`default_nettype wire

// File: rtl/rgb2gray_stage.sv
`default_nettype none
// ============================================================================
// Module      : rgb2gray_stage
// Description : RGB FIFO -> luma -> grayscale FIFO, 1 pixel/clk, 3-cycle
//               latency, back-pressure safe; GRAY_ROUND_EN selects rounding.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb2gray_stage
  import gray_pkg::*;
#(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 720,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  output logic              in_rd_en,
  input  logic [RGB_W-1:0]  in_dout,
  input  logic              in_empty,
  output logic              out_wr_en,
  output logic [GRAY_W-1:0] out_din,
  input  logic              out_full,
  output logic              frame_done
);

  localparam logic [CNT_W-1:0] c_last_pix = CNT_W'(WIDTH * HEIGHT - 1);

  logic [1:0]        r_occ;
  logic              r_r0_vld;
  logic              r_s1_vld;
  rgb_pix_t          r_s1_pix;
  logic              r_s2_vld;
  logic              r_s3_vld;
  logic [GRAY_W-1:0] r_out_din;
  logic [CNT_W-1:0]  r_pix_cnt;

  logic              w_drain;
  logic              w_rd;
  logic              w_s3_acc;
  logic              w_s3_ld;
  logic              w_s2_acc;
  logic              w_s2_ld;
  logic              w_s1_take;
  rgb_pix_t          w_mac_pix;
  logic [GRAY_W-1:0] w_mac_gray;
  logic              w_last;

  // S1 is a skid slot: returning data normally goes straight into the MAC
  // and only parks in S1 when S2 is blocked, which keeps latency at 3.
  always_comb begin
    w_drain   = r_s3_vld && !out_full;
    w_rd      = rst && !in_empty && ((r_occ != 2'd3) || w_drain);
    w_s3_acc  = !r_s3_vld || w_drain;
    w_s3_ld   = r_s2_vld && w_s3_acc;
    w_s2_acc  = !r_s2_vld || w_s3_ld;
    w_s2_ld   = w_s2_acc && (r_s1_vld || r_r0_vld);
    w_s1_take = r_r0_vld && (r_s1_vld || !w_s2_acc);
    w_mac_pix = r_s1_vld ? r_s1_pix : rgb_pix_t'(in_dout);
    w_last    = (r_pix_cnt == c_last_pix);
  end

  gray_mac u_gray_mac (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_s2_ld),
    .i_pix  (w_mac_pix),
    .o_gray (w_mac_gray)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ     <= 2'd0;
      r_r0_vld  <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s1_pix  <= '0;
      r_s2_vld  <= 1'b0;
      r_s3_vld  <= 1'b0;
      r_out_din <= '0;
      r_pix_cnt <= '0;
    end else begin
      r_r0_vld <= w_rd;
      if (w_rd && !w_drain) begin
        r_occ <= r_occ + 2'd1;
      end else if (w_drain && !w_rd) begin
        r_occ <= r_occ - 2'd1;
      end
      r_s1_vld <= w_s1_take || (r_s1_vld && !w_s2_ld);
      if (w_s1_take) begin
        r_s1_pix <= rgb_pix_t'(in_dout);
      end
      r_s2_vld <= w_s2_ld || (r_s2_vld && !w_s3_ld);
      r_s3_vld <= w_s3_ld || (r_s3_vld && !w_drain);
      if (w_s3_ld) begin
        r_out_din <= w_mac_gray;
      end
      if (w_drain) begin
        r_pix_cnt <= w_last ? '0 : r_pix_cnt + CNT_W'(1);
      end
    end
  end

  assign in_rd_en   = w_rd;
  assign out_wr_en  = w_drain;
  assign out_din    = r_out_din;
  assign frame_done = w_drain && w_last;

endmodule : rgb2gray_stage
`default_nettype wire
